// File: rtl/darkpc_seq.sv
// Fetch-PC sequencer: issues sequential fetch addresses, queues the PCs of
// outstanding fetches and tags each returned instruction with its PC.
module darkpc_seq #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              STEP     = 4,
   parameter int              DEPTH    = 2
) (
   input  logic                       clk,
   input  logic                       res,
   input  logic                       en,
   input  logic                       redir_valid,
   input  logic [XLEN-1:0]            redir_pc,
   output logic                       req_valid,
   output logic [XLEN-1:0]            req_pc,
   input  logic                       req_ready,
   input  logic                       rsp_valid,
   output logic                       rsp_pc_valid,
   output logic [XLEN-1:0]            rsp_pc,
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output logic                       err
);
   localparam int              CW      = $clog2(DEPTH+1);
   localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0]   LAST    = PW'(DEPTH-1);
   localparam logic [XLEN-1:0] STEP_C  = XLEN'(STEP);
   localparam logic [XLEN-1:0] ALIGN   = ~(STEP_C - 1'b1);

   typedef enum logic {BOOT, RUN} state_t;

   state_t                      state;
   logic [XLEN-1:0]             pc;
   logic [DEPTH-1:0][XLEN-1:0]  q;
   logic [PW-1:0]               head, tail;
   logic [CW-1:0]               cnt, kill;
   logic                        push, pop;

   assign req_pc      = pc;
   assign req_valid   = (state == RUN) && en && (cnt < DEPTH_C) && !redir_valid;
   assign push        = req_valid && req_ready;
   assign pop         = rsp_valid && (cnt != '0);
   assign outstanding = cnt;

   always_ff @(posedge clk) begin
      if (!res) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         q            <= '0;
         head         <= '0;
         tail         <= '0;
         cnt          <= '0;
         kill         <= '0;
         rsp_pc_valid <= 1'b0;
         rsp_pc       <= '0;
         err          <= 1'b0;
      end else begin
         if (state == BOOT && (en || redir_valid))
            state <= RUN;

         if (redir_valid)
            pc <= redir_pc & ALIGN;
         else if (push)
            pc <= pc + STEP_C;

         if (push) begin
            q[tail] <= pc;
            tail    <= (tail == LAST) ? '0 : tail + 1'b1;
         end
         if (pop)
            head <= (head == LAST) ? '0 : head + 1'b1;
         cnt <= cnt + CW'(push) - CW'(pop);

         // A pop in the redirect cycle is judged by the old kill count;
         // only entries left after it become dead.
         if (redir_valid)
            kill <= cnt - CW'(pop);
         else if (pop && kill != '0)
            kill <= kill - 1'b1;

         rsp_pc_valid <= pop && (kill == '0);
         if (pop && kill == '0)
            rsp_pc <= q[head];

         if (rsp_valid && cnt == '0)
            err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_darkpc_seq.sv
// Directed bench for darkpc_seq: one task per scenario, inline checks against
// hand-computed values; a second instance covers address wrap and err.
module tb_darkpc_seq;
   logic        clk = 1'b0;
   logic        res, en, redir_valid, req_ready, rsp_valid;
   logic [31:0] redir_pc;
   logic        req_valid, rsp_pc_valid, err;
   logic [31:0] req_pc, rsp_pc;
   logic [1:0]  outstanding;

   logic        res2, en2, redir_valid2, req_ready2, rsp_valid2;
   logic [31:0] redir_pc2;
   logic        req_valid2, rsp_pc_valid2, err2;
   logic [31:0] req_pc2, rsp_pc2;
   logic [1:0]  outstanding2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   darkpc_seq dut (
      .clk(clk), .res(res), .en(en), .redir_valid(redir_valid), .redir_pc(redir_pc),
      .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_pc_valid(rsp_pc_valid), .rsp_pc(rsp_pc), .outstanding(outstanding), .err(err)
   );

   darkpc_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .res(res2), .en(en2), .redir_valid(redir_valid2), .redir_pc(redir_pc2),
      .req_valid(req_valid2), .req_pc(req_pc2), .req_ready(req_ready2), .rsp_valid(rsp_valid2),
      .rsp_pc_valid(rsp_pc_valid2), .rsp_pc(rsp_pc2), .outstanding(outstanding2), .err(err2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      redir_valid = 0; rsp_valid = 0; req_ready = 0; res = 0;
      step();
      res = 1; en = 1;
   endtask

   task automatic test_reset();
      res = 0; en = 0;
      step(); step();
      n_cmp++; if ({req_valid, outstanding, err, rsp_pc_valid} !== 5'b0)
         begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {req_valid, outstanding, err, rsp_pc_valid}); end
      n_cmp++; if (rsp_pc !== 32'h0)
         begin n_bad++; $display("FAIL reset_rsp_pc: got %h want 0", rsp_pc); end
      res = 1;
      step();
      n_cmp++; if (req_valid !== 1'b0 || outstanding !== 2'd0)
         begin n_bad++; $display("FAIL boot_idle: got v=%b o=%0d want v=0 o=0", req_valid, outstanding); end
      en = 1; #1;
      n_cmp++; if (req_valid !== 1'b0)
         begin n_bad++; $display("FAIL boot_en_same_cycle: got %b want 0", req_valid); end
      step();
      n_cmp++; if (req_valid !== 1'b1 || req_pc !== 32'h0)
         begin n_bad++; $display("FAIL run_first_req: got v=%b pc=%h want v=1 pc=0", req_valid, req_pc); end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 5; i++) begin
         req_ready = (i < 4); rsp_valid = (i > 0); #1;
         if (i < 4) begin
            n_cmp++; if (req_valid !== 1'b1 || req_pc !== 32'(4*i))
               begin n_bad++; $display("FAIL stream_req[%0d]: got v=%b pc=%h want v=1 pc=%h", i, req_valid, req_pc, 32'(4*i)); end
         end
         step();
         if (i > 0) begin
            n_cmp++; if (rsp_pc_valid !== 1'b1 || rsp_pc !== 32'(4*(i-1)))
               begin n_bad++; $display("FAIL stream_rsp[%0d]: got v=%b pc=%h want v=1 pc=%h", i, rsp_pc_valid, rsp_pc, 32'(4*(i-1))); end
         end
         n_cmp++; if (outstanding !== ((i < 4) ? 2'd1 : 2'd0))
            begin n_bad++; $display("FAIL stream_occ[%0d]: got %0d want %0d", i, outstanding, (i < 4) ? 1 : 0); end
      end
      req_ready = 0; rsp_valid = 0;
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b0 || rsp_pc !== 32'hC)
         begin n_bad++; $display("FAIL stream_hold: got v=%b pc=%h want v=0 pc=c", rsp_pc_valid, rsp_pc); end
   endtask

   task automatic test_backpressure();
      do_reset();
      step();
      req_ready = 1;
      step(); step();
      req_ready = 0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (req_valid !== 1'b0 || req_pc !== 32'h8 || outstanding !== 2'd2)
            begin n_bad++; $display("FAIL bp_stall[%0d]: got v=%b pc=%h o=%0d want v=0 pc=8 o=2", i, req_valid, req_pc, outstanding); end
         step();
      end
      rsp_valid = 1; req_ready = 1; #1;
      n_cmp++; if (req_valid !== 1'b0)
         begin n_bad++; $display("FAIL bp_full_pop: got %b want 0", req_valid); end
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b1 || rsp_pc !== 32'h0 || outstanding !== 2'd1)
         begin n_bad++; $display("FAIL bp_rsp0: got v=%b pc=%h o=%0d want v=1 pc=0 o=1", rsp_pc_valid, rsp_pc, outstanding); end
      rsp_valid = 0; #1;
      n_cmp++; if (req_valid !== 1'b1 || req_pc !== 32'h8)
         begin n_bad++; $display("FAIL bp_reissue: got v=%b pc=%h want v=1 pc=8", req_valid, req_pc); end
      step();
      req_ready = 0;
      n_cmp++; if (outstanding !== 2'd2 || rsp_pc_valid !== 1'b0 || rsp_pc !== 32'h0)
         begin n_bad++; $display("FAIL bp_after_push: got o=%0d v=%b pc=%h want o=2 v=0 pc=0", outstanding, rsp_pc_valid, rsp_pc); end
      rsp_valid = 1;
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b1 || rsp_pc !== 32'h4)
         begin n_bad++; $display("FAIL bp_rsp4: got v=%b pc=%h want v=1 pc=4", rsp_pc_valid, rsp_pc); end
      step();
      n_cmp++; if (rsp_pc !== 32'h8 || outstanding !== 2'd0)
         begin n_bad++; $display("FAIL bp_rsp8: got pc=%h o=%0d want pc=8 o=0", rsp_pc, outstanding); end
      rsp_valid = 0;
   endtask

   task automatic test_redirect();
      do_reset();
      redir_valid = 1; redir_pc = 32'h10; #1;
      n_cmp++; if (req_valid !== 1'b0)
         begin n_bad++; $display("FAIL redir_boot_req: got %b want 0", req_valid); end
      step();
      redir_valid = 0; req_ready = 1;
      step(); step();
      n_cmp++; if (outstanding !== 2'd2)
         begin n_bad++; $display("FAIL redir_fill: got %0d want 2", outstanding); end
      redir_valid = 1; redir_pc = 32'h103; #1;
      n_cmp++; if (req_valid !== 1'b0)
         begin n_bad++; $display("FAIL redir_blocks_req: got %b want 0", req_valid); end
      step();
      redir_valid = 0; #1;
      n_cmp++; if (req_pc !== 32'h100 || req_valid !== 1'b0)
         begin n_bad++; $display("FAIL redir_target: got pc=%h v=%b want pc=100 v=0", req_pc, req_valid); end
      rsp_valid = 1;
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b0 || rsp_pc !== 32'h0 || outstanding !== 2'd1)
         begin n_bad++; $display("FAIL redir_kill1: got v=%b pc=%h o=%0d want v=0 pc=0 o=1", rsp_pc_valid, rsp_pc, outstanding); end
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b0 || outstanding !== 2'd1)
         begin n_bad++; $display("FAIL redir_kill2: got v=%b o=%0d want v=0 o=1", rsp_pc_valid, outstanding); end
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b1 || rsp_pc !== 32'h100)
         begin n_bad++; $display("FAIL redir_live: got v=%b pc=%h want v=1 pc=100", rsp_pc_valid, rsp_pc); end
      req_ready = 0;
      step();
      n_cmp++; if (rsp_pc !== 32'h104 || outstanding !== 2'd0)
         begin n_bad++; $display("FAIL redir_drain: got pc=%h o=%0d want pc=104 o=0", rsp_pc, outstanding); end
      rsp_valid = 0;
   endtask

   task automatic test_redir_pop();
      do_reset();
      redir_valid = 1; redir_pc = 32'h10;
      step();
      redir_valid = 0; req_ready = 1;
      step(); step();
      req_ready = 0; redir_valid = 1; redir_pc = 32'h200; rsp_valid = 1;
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b1 || rsp_pc !== 32'h10 || outstanding !== 2'd1)
         begin n_bad++; $display("FAIL rpop_live: got v=%b pc=%h o=%0d want v=1 pc=10 o=1", rsp_pc_valid, rsp_pc, outstanding); end
      redir_valid = 0;
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b0 || rsp_pc !== 32'h10 || outstanding !== 2'd0)
         begin n_bad++; $display("FAIL rpop_killed: got v=%b pc=%h o=%0d want v=0 pc=10 o=0", rsp_pc_valid, rsp_pc, outstanding); end
      rsp_valid = 0; req_ready = 1; #1;
      n_cmp++; if (req_pc !== 32'h200 || req_valid !== 1'b1)
         begin n_bad++; $display("FAIL rpop_target: got pc=%h v=%b want pc=200 v=1", req_pc, req_valid); end
      step();
      req_ready = 0; rsp_valid = 1;
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b1 || rsp_pc !== 32'h200)
         begin n_bad++; $display("FAIL rpop_after: got v=%b pc=%h want v=1 pc=200", rsp_pc_valid, rsp_pc); end
      rsp_valid = 0;
   endtask

   task automatic test_back_to_back();
      req_ready = 1;
      step(); step();
      req_ready = 0; redir_valid = 1; redir_pc = 32'h300;
      step();
      redir_pc = 32'h405; rsp_valid = 1;
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b0 || outstanding !== 2'd1 || rsp_pc !== 32'h200)
         begin n_bad++; $display("FAIL b2b_kill1: got v=%b o=%0d pc=%h want v=0 o=1 pc=200", rsp_pc_valid, outstanding, rsp_pc); end
      redir_valid = 0;
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b0 || outstanding !== 2'd0)
         begin n_bad++; $display("FAIL b2b_kill2: got v=%b o=%0d want v=0 o=0", rsp_pc_valid, outstanding); end
      rsp_valid = 0; req_ready = 1; #1;
      n_cmp++; if (req_pc !== 32'h404 || req_valid !== 1'b1)
         begin n_bad++; $display("FAIL b2b_target: got pc=%h v=%b want pc=404 v=1", req_pc, req_valid); end
      step();
      req_ready = 0; rsp_valid = 1;
      step();
      n_cmp++; if (rsp_pc_valid !== 1'b1 || rsp_pc !== 32'h404)
         begin n_bad++; $display("FAIL b2b_live: got v=%b pc=%h want v=1 pc=404", rsp_pc_valid, rsp_pc); end
      rsp_valid = 0;
   endtask

   task automatic test_wrap_err();
      res2 = 0; en2 = 0;
      step();
      n_cmp++; if (req_pc2 !== 32'hFFFF_FFFC || req_valid2 !== 1'b0)
         begin n_bad++; $display("FAIL wrap_reset_pc: got pc=%h v=%b want pc=fffffffc v=0", req_pc2, req_valid2); end
      res2 = 1; en2 = 1; req_ready2 = 1;
      step();
      n_cmp++; if (req_valid2 !== 1'b1 || req_pc2 !== 32'hFFFF_FFFC)
         begin n_bad++; $display("FAIL wrap_req0: got v=%b pc=%h want v=1 pc=fffffffc", req_valid2, req_pc2); end
      step();
      n_cmp++; if (req_pc2 !== 32'h0)
         begin n_bad++; $display("FAIL wrap_req1: got %h want 0", req_pc2); end
      step();
      req_ready2 = 0; rsp_valid2 = 1;
      step();
      n_cmp++; if (rsp_pc_valid2 !== 1'b1 || rsp_pc2 !== 32'hFFFF_FFFC)
         begin n_bad++; $display("FAIL wrap_rsp0: got v=%b pc=%h want v=1 pc=fffffffc", rsp_pc_valid2, rsp_pc2); end
      step();
      n_cmp++; if (rsp_pc2 !== 32'h0 || outstanding2 !== 2'd0 || err2 !== 1'b0)
         begin n_bad++; $display("FAIL wrap_rsp1: got pc=%h o=%0d e=%b want pc=0 o=0 e=0", rsp_pc2, outstanding2, err2); end
      step();
      n_cmp++; if (err2 !== 1'b1 || rsp_pc_valid2 !== 1'b0 || outstanding2 !== 2'd0)
         begin n_bad++; $display("FAIL err_set: got e=%b v=%b o=%0d want e=1 v=0 o=0", err2, rsp_pc_valid2, outstanding2); end
      rsp_valid2 = 0;
      step(); step();
      n_cmp++; if (err2 !== 1'b1)
         begin n_bad++; $display("FAIL err_sticky: got %b want 1", err2); end
      res2 = 0;
      step();
      n_cmp++; if (err2 !== 1'b0)
         begin n_bad++; $display("FAIL err_clear: got %b want 0", err2); end
   endtask

   initial begin
      res = 0; en = 0; redir_valid = 0; redir_pc = 0; req_ready = 0; rsp_valid = 0;
      res2 = 0; en2 = 0; redir_valid2 = 0; redir_pc2 = 0; req_ready2 = 0; rsp_valid2 = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redir_pop();
      test_back_to_back();
      test_wrap_err();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
